// File: rtl/dram_line_sequencer_if.sv
// Bus bundle for dram_line_sequencer: client request/response channel plus the
// memory controller's address FIFO, write buffer and read buffer ports.
// Also declares iu_clk_type, the clock bundle used for gclk.
// The sequencer uses the slave modport; the client/controller side uses master.

typedef struct packed {
  logic clk;
} iu_clk_type;

interface dram_line_sequencer_if;
  // Client request channel
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [27:0]  req_addr;
  logic [287:0] req_wdata;
  // Client response channel
  logic         resp_valid;
  logic         resp_ready;
  logic [287:0] resp_data;
  logic         resp_err;
  // Controller address FIFO
  logic [27:0]  af_addr;
  logic         af_read;
  logic         af_we;
  logic         af_full;
  // Controller write buffer
  logic [143:0] wb_data;
  logic         wb_we;
  logic         wb_full;
  // Controller read buffer
  logic         rb_re;
  logic         rb_empty;
  logic [143:0] rb_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_data, resp_err,
    input  resp_ready,
    output af_addr, af_read, af_we,
    input  af_full,
    output wb_data, wb_we,
    input  wb_full,
    output rb_re,
    input  rb_empty, rb_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_data, resp_err,
    output resp_ready,
    input  af_addr, af_read, af_we,
    output af_full,
    input  wb_data, wb_we,
    output wb_full,
    input  rb_re,
    output rb_empty, rb_data
  );
endinterface

// File: rtl/dram_line_sequencer.sv
// dram_line_sequencer: turns 288-bit line requests into memory-controller
// address FIFO / write buffer / read buffer traffic. Writes go out as one
// address plus two 144-bit beats; reads are issued immediately (up to
// MAX_OUTSTANDING in flight) and two read-buffer beats are gathered per response.
// Optional feature macro DRAM_BYTE_PARITY_EN: replaces each beat's ecc field
// with even byte parity on writes and flags parity errors on returned beats.

module dram_line_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input iu_clk_type             gclk,
  input logic                   rst,
  dram_line_sequencer_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWr0  = 2'd1;
  localparam logic [1:0] StWr1  = 2'd2;

  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

  logic [1:0]   state_q, state_d;
  logic [27:0]  addr_q;
  logic [287:0] wdata_q;
  logic [3:0]   outstanding_q;
  logic [1:0]   pops_q;
  logic         cap_q;          // rb_re was pulsed last cycle, rb_data is valid now
  logic [143:0] beat0_q;
  logic         err0_q;
  logic         resp_valid_q;
  logic [287:0] resp_data_q;
  logic         resp_err_q;

  logic         idle;
  logic         wr_take;
  logic         rd_go;
  logic         wr0_go;
  logic         wr1_go;
  logic         rb_go;
  logic         resp_fire;
  logic [143:0] wb_beat0;
  logic [143:0] wb_beat1;
  logic         rb_bad;

`ifdef DRAM_BYTE_PARITY_EN
  function automatic logic [15:0] byte_parity(input logic [127:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Outgoing beats carry computed parity; returned beats are checked against it
  always_comb begin
    wb_beat0 = {byte_parity(wdata_q[127:0]), wdata_q[127:0]};
    wb_beat1 = {byte_parity(wdata_q[271:144]), wdata_q[271:144]};
    rb_bad   = (byte_parity(bus.rb_data[127:0]) != bus.rb_data[143:128]);
  end
`else
  // Ecc fields pass through untouched; no error reporting
  always_comb begin
    wb_beat0 = wdata_q[143:0];
    wb_beat1 = wdata_q[287:144];
    rb_bad   = 1'b0;
  end
`endif

  // Strobe decisions; every strobe is forced low while rst is high
  always_comb begin
    idle      = (state_q == StIdle);
    wr_take   = !rst && idle && bus.req_valid && bus.req_we;
    rd_go     = !rst && idle && bus.req_valid && !bus.req_we && !bus.af_full &&
                (outstanding_q < MaxOut);
    wr0_go    = !rst && (state_q == StWr0) && !bus.af_full && !bus.wb_full;
    wr1_go    = !rst && (state_q == StWr1) && !bus.wb_full;
    // Never drain the read buffer with a response pending or nothing in flight
    rb_go     = !rst && !bus.rb_empty && (outstanding_q != 4'd0) && (pops_q < 2'd2) &&
                !resp_valid_q;
    resp_fire = resp_valid_q && bus.resp_ready;
  end

  // Controller and client outputs
  always_comb begin
    bus.req_ready  = wr_take || rd_go;
    bus.af_we      = rd_go || wr0_go;
    bus.af_read    = rd_go;
    bus.af_addr    = idle ? bus.req_addr : addr_q;
    bus.wb_we      = wr0_go || wr1_go;
    bus.wb_data    = (state_q == StWr1) ? wb_beat1 : wb_beat0;
    bus.rb_re      = rb_go;
    bus.resp_valid = resp_valid_q;
    bus.resp_data  = resp_data_q;
    bus.resp_err   = resp_err_q;
  end

  // Write-sequencing FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (wr_take) state_d = StWr0;
      StWr0:   if (wr0_go)  state_d = StWr1;
      StWr1:   if (wr1_go)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, request latch, read tracking and response registers
  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      outstanding_q <= '0;
      pops_q        <= '0;
      cap_q         <= 1'b0;
      beat0_q       <= '0;
      err0_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_take) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // A simultaneous issue and retire cancel out
      if (rd_go && !resp_fire) begin
        outstanding_q <= outstanding_q + 4'd1;
      end else if (!rd_go && resp_fire) begin
        outstanding_q <= outstanding_q - 4'd1;
      end
      cap_q <= rb_go;
      if (rb_go) begin
        pops_q <= pops_q + 2'd1;
      end
      // pops_q == 2 here means the beat arriving now is the second of the line
      if (cap_q) begin
        if (pops_q == 2'd2) begin
          resp_data_q  <= {bus.rb_data, beat0_q};
          resp_err_q   <= err0_q || rb_bad;
          resp_valid_q <= 1'b1;
          pops_q       <= 2'd0;
        end else begin
          beat0_q <= bus.rb_data;
          err0_q  <= rb_bad;
        end
      end
      if (resp_fire) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_line_sequencer.sv
// Directed bench for dram_line_sequencer: a cycle table for write issue/stall,
// read return and reset abandon, plus hand sequences for the outstanding limit,
// simultaneous issue/retire and parity behaviour.

module tb_dram_line_sequencer;

`ifdef DRAM_BYTE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  iu_clk_type gclk;

  assign gclk.clk = clk;

  dram_line_sequencer_if bus();

  dram_line_sequencer #(.MAX_OUTSTANDING(4)) dut (
    .gclk (gclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [143:0] beat_a, beat_b, beat_c, beat_d, beat_cbad;

  typedef struct {
    int          rst, rv, we;
    logic [27:0] addr;
    int          aff, wbf, rbe, rbsel, rr;
    int          e_rdy, e_afwe, e_afrd;
    logic [27:0] e_addr;
    int          e_wbwe, e_wbsel, e_rbre, e_rv, e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] par16(input logic [127:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  // A beat as the controller would store it (parity replaces ecc when enabled)
  function automatic logic [143:0] mk_beat(input logic [15:0] ecc, input logic [127:0] d);
    return PAR_EN ? {par16(d), d} : {ecc, d};
  endfunction

  function automatic logic [143:0] wb_exp(input logic [143:0] b);
    return mk_beat(b[143:128], b[127:0]);
  endfunction

  function automatic logic [143:0] rb_of(input int sel);
    case (sel)
      1:       return beat_c;
      2:       return beat_d;
      3:       return beat_cbad;
      default: return '0;
    endcase
  endfunction

  function automatic vec_t mk(input int rst_v, rv, we, input logic [27:0] addr,
                              input int aff, wbf, rbe, rbsel, rr,
                              input int e_rdy, e_afwe, e_afrd, input logic [27:0] e_addr,
                              input int e_wbwe, e_wbsel, e_rbre, e_rv, e_data);
    vec_t v;
    v.rst = rst_v; v.rv = rv; v.we = we; v.addr = addr;
    v.aff = aff; v.wbf = wbf; v.rbe = rbe; v.rbsel = rbsel; v.rr = rr;
    v.e_rdy = e_rdy; v.e_afwe = e_afwe; v.e_afrd = e_afrd; v.e_addr = e_addr;
    v.e_wbwe = e_wbwe; v.e_wbsel = e_wbsel; v.e_rbre = e_rbre; v.e_rv = e_rv;
    v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic we, input logic [27:0] addr,
                        input logic aff, input logic wbf, input logic rbe,
                        input logic [143:0] rbd, input logic rr);
    bus.req_valid  = rv;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = {beat_b, beat_a};
    bus.af_full    = aff;
    bus.wb_full    = wbf;
    bus.rb_empty   = rbe;
    bus.rb_data    = rbd;
    bus.resp_ready = rr;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int acc;

  initial begin
    beat_a    = {16'hA5A5, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E101};
    beat_b    = {16'h5A5A, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98};
    beat_c    = mk_beat(16'h1111, 128'h11223344_55667788_99AABBCC_DDEEFF00);
    beat_d    = mk_beat(16'h2222, 128'hCAFEF00D_12345678_0BADC0DE_87654321);
    beat_cbad = beat_c ^ (144'h1 << 128);

    //           rst rv we addr     aff wbf rbe sel rr | rdy afwe afrd eaddr  wbwe sel rbre rv data
    tbl.push_back(mk(1, 1, 0, 28'h40,  0, 0, 0, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    // Single write, fifos empty
    tbl.push_back(mk(0, 1, 1, 28'h40,  0, 0, 1, 0, 0,   1, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 1, 0, 28'h40,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    // Write with wb_full for 3 cycles in WR1
    tbl.push_back(mk(0, 1, 1, 28'h80,  0, 0, 1, 0, 0,   1, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 1, 0, 28'h80,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 1, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 1, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 1, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    // Write with af_full stall in WR0
    tbl.push_back(mk(0, 1, 1, 28'hC0,  0, 0, 1, 0, 0,   1, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   1, 0, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 1, 0, 28'hC0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   1, 2, 0, 0, 0));
    // Read, two beats returned, resp_ready held low two cycles
    tbl.push_back(mk(0, 1, 0, 28'h100, 0, 0, 1, 0, 0,   1, 1, 1, 28'h100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 0, 0,   0, 0, 0, 28'h0,   0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 1, 0,   0, 0, 0, 28'h0,   0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 2, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 0, 1,   0, 0, 0, 28'h0,   0, 0, 0, 1, 1));
    // Nothing outstanding: a non-empty read buffer must be left alone
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 0, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    // Reset in the middle of a stalled write abandons it
    tbl.push_back(mk(0, 1, 1, 28'h200, 0, 0, 0, 0, 0,   1, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 1, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 28'h0,   0, 0, 1, 0, 0,   0, 0, 0, 28'h0,   0, 0, 0, 0, 0));

    rst = 1'b1;
    idle_in();
    @(negedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      rst = (tbl[i].rst != 0);
      set_in(tbl[i].rv != 0, tbl[i].we != 0, tbl[i].addr, tbl[i].aff != 0, tbl[i].wbf != 0,
             tbl[i].rbe != 0, rb_of(tbl[i].rbsel), tbl[i].rr != 0);
      #1;
      chk($sformatf("v%0d req_ready", i), bus.req_ready, 288'(tbl[i].e_rdy));
      chk($sformatf("v%0d af_we", i), bus.af_we, 288'(tbl[i].e_afwe));
      chk($sformatf("v%0d wb_we", i), bus.wb_we, 288'(tbl[i].e_wbwe));
      chk($sformatf("v%0d rb_re", i), bus.rb_re, 288'(tbl[i].e_rbre));
      chk($sformatf("v%0d resp_valid", i), bus.resp_valid, 288'(tbl[i].e_rv));
      if (tbl[i].e_afwe != 0) begin
        chk($sformatf("v%0d af_read", i), bus.af_read, 288'(tbl[i].e_afrd));
        chk($sformatf("v%0d af_addr", i), bus.af_addr, tbl[i].e_addr);
      end
      if (tbl[i].e_wbwe != 0) begin
        chk($sformatf("v%0d wb_data", i), bus.wb_data,
            wb_exp(tbl[i].e_wbsel == 1 ? beat_a : beat_b));
      end
      if (tbl[i].e_data != 0) begin
        chk($sformatf("v%0d resp_data", i), bus.resp_data, {beat_d, beat_c});
        chk($sformatf("v%0d resp_err", i), bus.resp_err, 288'(0));
      end
      @(negedge clk);
    end
    rst = 1'b0;

    // Outstanding limit: five reads, only four issue until a response retires
    reset_dut();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      int a;
      a = (i < 4) ? i : 4;
      set_in(1'b1, 1'b0, 28'(16 + a), 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
      #1;
      chk($sformatf("lim%0d req_ready", i), bus.req_ready, 288'(i < 4));
      if (bus.af_we && bus.af_read) acc++;
      @(negedge clk);
    end
    chk("lim af_we count", 288'(acc), 288'(4));
    set_in(1'b1, 1'b0, 28'h14, 1'b0, 1'b0, 1'b0, 144'h0, 1'b0);
    #1;
    chk("lim pop0 rb_re", bus.rb_re, 288'(1));
    chk("lim pop0 req_ready", bus.req_ready, 288'(0));
    @(negedge clk);
    set_in(1'b1, 1'b0, 28'h14, 1'b0, 1'b0, 1'b0, beat_c, 1'b0);
    #1;
    chk("lim pop1 rb_re", bus.rb_re, 288'(1));
    @(negedge clk);
    set_in(1'b1, 1'b0, 28'h14, 1'b0, 1'b0, 1'b1, beat_d, 1'b0);
    #1;
    chk("lim cap rb_re", bus.rb_re, 288'(0));
    @(negedge clk);
    set_in(1'b1, 1'b0, 28'h14, 1'b0, 1'b0, 1'b1, 144'h0, 1'b1);
    #1;
    chk("lim hs resp_valid", bus.resp_valid, 288'(1));
    chk("lim hs resp_data", bus.resp_data, {beat_d, beat_c});
    chk("lim hs req_ready", bus.req_ready, 288'(0));
    @(negedge clk);
    set_in(1'b1, 1'b0, 28'h14, 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
    #1;
    chk("lim post resp_valid", bus.resp_valid, 288'(0));
    chk("lim post req_ready", bus.req_ready, 288'(1));
    chk("lim post af_addr", bus.af_addr, 288'(28'h14));
    @(negedge clk);
    idle_in();

    // Read accepted in the same cycle as a response handshake, two in flight
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 28'(32 + i), 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
      #1;
      chk($sformatf("sim rd%0d req_ready", i), bus.req_ready, 288'(1));
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 144'h0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, beat_c, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b1, beat_d, 1'b0);
    @(negedge clk);
    set_in(1'b1, 1'b0, 28'h22, 1'b0, 1'b0, 1'b1, 144'h0, 1'b1);
    #1;
    chk("sim resp_valid", bus.resp_valid, 288'(1));
    chk("sim req_ready", bus.req_ready, 288'(1));
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 28'(35 + i), 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
      #1;
      if (bus.req_ready) acc++;
      @(negedge clk);
    end
    chk("sim extra accepts", 288'(acc), 288'(2));
    idle_in();

    // Returned beat with bit 128 flipped
    reset_dut();
    set_in(1'b1, 1'b0, 28'h30, 1'b0, 1'b0, 1'b1, 144'h0, 1'b0);
    #1;
    chk("par rd req_ready", bus.req_ready, 288'(1));
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 144'h0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, beat_cbad, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b1, beat_d, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b1, 144'h0, 1'b1);
    #1;
    chk("par resp_valid", bus.resp_valid, 288'(1));
    chk("par resp_data", bus.resp_data, {beat_d, beat_cbad});
    chk("par resp_err", bus.resp_err, 288'(PAR_EN));
    @(negedge clk);
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
